display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit 7-seg display of the add/sub lab.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/slot_timer.sv | 30 +++
 rtl/display_scan_ctrl.sv | 118 +++++++++++
 tb/tb_display_scan_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit 7-seg scan controller.
//   AN_*   : active-low anode patterns (an[0] = rightmost digit)
//   SEL_*  : digit-select codes understood by the display decode stage
//   ST_*   : per-slot scan state encoding
package display_pkg;

  localparam int unsigned RES_W = 9;

  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [3:0] AN_UNITS = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_HUND  = 4'b1011;
  localparam logic [3:0] AN_SIGN  = 4'b0111;

  localparam logic [1:0] SEL_UNITS = 2'b00;
  localparam logic [1:0] SEL_SIGN  = 2'b01;
  localparam logic [1:0] SEL_HUND  = 2'b10;
  localparam logic [1:0] SEL_TENS  = 2'b11;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // Operator/result pair as presented to the display stage.
  typedef struct packed {
    logic             op;
    logic [RES_W-1:0] res;
  } disp_data_t;

  // Anode pattern lighting the digit addressed by sel.
  function automatic logic [3:0] an_code(input logic [1:0] sel);
    logic [3:0] code;
    code = AN_OFF;
    case (sel)
      SEL_UNITS: code = AN_UNITS;
      SEL_SIGN:  code = AN_SIGN;
      SEL_HUND:  code = AN_HUND;
      SEL_TENS:  code = AN_TENS;
      default:   code = AN_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Digit-slot timer: counts 0..DIV-1 and flags the two slot landmarks.
//   clk, rst    : clock, synchronous active-high reset
//   slot_end_c  : last cycle of the slot (counter wraps on the next edge)
//   show_en_c   : last blanking cycle (anode may turn on at the next edge)
// Requires DIV >= 4 and 1 <= BLANK_CYC < DIV.
module slot_timer #(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end_c,
  output logic show_en_c
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] slot_cnt;

  assign slot_end_c = (slot_cnt == CNT_W'(DIV - 1));
  assign show_en_c  = (slot_cnt == CNT_W'(BLANK_CYC - 1));

  // Free-running slot counter.
  always_ff @(posedge clk) begin
    if (rst)             slot_cnt <= '0;
    else if (slot_end_c) slot_cnt <= '0;
    else                 slot_cnt <= slot_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 4-digit 7-seg display.
//   clk, rst          : clock, synchronous active-high reset
//   load, op_in,
//   res_in            : 1-cycle strobe capturing operator and 9-bit result
//   op_q, res_q       : displayed op/result, updated only at frame start
//   sel_disp          : digit select to the decode stage (order 00,01,10,11)
//   an                : active-low anodes, all off during each slot's blanking
//   frame_start       : 1-cycle pulse on the first cycle of slot 0
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             op_in,
  input  logic [RES_W-1:0] res_in,
  output logic             op_q,
  output logic [RES_W-1:0] res_q,
  output logic [1:0]       sel_disp,
  output logic [3:0]       an,
  output logic             frame_start
);

  localparam logic [1:0] LAST_DIGIT = 2'd3;

  logic       slot_end_c;
  logic       show_en_c;
  logic       frame_edge_c;
  logic [1:0] digit;
  logic [0:0] state;
  logic [0:0] state_next;
  logic [3:0] an_next;
  logic       pending;
  disp_data_t shadow;
  disp_data_t shown;

  slot_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_end_c (slot_end_c),
    .show_en_c  (show_en_c)
  );

  // The edge that enters slot 0 is the only point where displayed data may change.
  assign frame_edge_c = slot_end_c && (digit == LAST_DIGIT);

  assign sel_disp = digit;
  assign op_q     = shown.op;
  assign res_q    = shown.res;

  // Digit index advances once per slot.
  always_ff @(posedge clk) begin
    if (rst)             digit <= '0;
    else if (slot_end_c) digit <= digit + 2'd1;
  end

  // Scan FSM state and anode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      an    <= AN_OFF;
    end else begin
      state <= state_next;
      an    <= an_next;
    end
  end

  // Anodes turn on after blanking and off at the slot boundary, in step with sel_disp.
  always_comb begin
    state_next = state;
    an_next    = an;
    case (state)
      ST_BLANK: begin
        if (show_en_c) begin
          state_next = ST_SHOW;
          an_next    = an_code(digit);
        end
      end
      ST_SHOW: begin
        if (slot_end_c) begin
          state_next = ST_BLANK;
          an_next    = AN_OFF;
        end
      end
      default: begin
        state_next = ST_BLANK;
        an_next    = AN_OFF;
      end
    endcase
  end

  // Shadow/pending hold: loads wait for the next frame; a load on the frame edge bypasses.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      shown       <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge_c;
      if (load) shadow <= '{op: op_in, res: res_in};
      if (frame_edge_c) begin
        pending <= 1'b0;
        if (load)         shown <= '{op: op_in, res: res_in};
        else if (pending) shown <= shadow;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=8, BLANK_CYC=2).
module tb_display_scan_ctrl;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       op_in;
  logic [8:0] res_in;
  logic       op_q;
  logic [8:0] res_q;
  logic [1:0] sel_disp;
  logic [3:0] an;
  logic       frame_start;

  display_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .op_in       (op_in),
    .res_in      (res_in),
    .op_q        (op_q),
    .res_q       (res_q),
    .sel_disp    (sel_disp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles since reset release, displayed and buffered data.
  int         t;
  logic       m_op;
  logic [8:0] m_res;
  logic       m_pend;
  logic       sh_op;
  logic [8:0] sh_res;
  logic [3:0] an_map [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
  endtask

  task automatic model_reset();
    t      = 0;
    m_op   = 1'b0;
    m_res  = '0;
    m_pend = 1'b0;
    sh_op  = 1'b0;
    sh_res = '0;
  endtask

  // Check cycle t, drive inputs for it, advance the model across the edge.
  task automatic step(input logic ld, input logic op, input logic [8:0] res);
    int slot, pos;
    slot = (t / DIV) % 4;
    pos  = t % DIV;
    check("sel_disp", 32'(sel_disp), 32'(slot));
    check("an", 32'(an), (pos < BLANK) ? 32'hF : 32'(an_map[slot]));
    check("one_anode", 32'($countones(~an) <= 1), 32'd1);
    check("frame_start", 32'(frame_start), 32'(t > 0 && (t % FRAME) == 0));
    check("op_q", 32'(op_q), 32'(m_op));
    check("res_q", 32'(res_q), 32'(m_res));
    load   = ld;
    op_in  = op;
    res_in = res;
    if (((t + 1) % FRAME) == 0) begin
      if (ld) begin
        m_op  = op;
        m_res = res;
      end else if (m_pend) begin
        m_op  = sh_op;
        m_res = sh_res;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      sh_op  = op;
      sh_res = res;
      m_pend = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic step_rand(input int prob);
    logic       ld;
    logic       op;
    logic [8:0] res;
    ld  = ($urandom_range(0, 99) < prob);
    op  = 1'($urandom);
    res = 9'($urandom);
    step(ld, op, res);
  endtask

  task automatic do_reset(input int hold);
    rst  = 1'b1;
    load = 1'b0;
    repeat (hold) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sel", 32'(sel_disp), 32'd0);
    check("rst_res", 32'(res_q), 32'd0);
    check("rst_op", 32'(op_q), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    an_map[0] = 4'b1110;
    an_map[1] = 4'b0111;
    an_map[2] = 4'b1011;
    an_map[3] = 4'b1101;
    load   = 1'b0;
    op_in  = 1'b0;
    res_in = '0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Directed loads: slot-1 load, two loads in one frame, load on the frame edge,
    // then a buffered load left pending when reset hits slot 2.
    while (t < 148) begin
      case (t)
        10:      step(1'b1, 1'b1, 9'h1F6);
        40:      step(1'b1, 1'b0, 9'h005);
        50:      step(1'b1, 1'b0, 9'h0C8);
        95:      step(1'b1, 1'b0, 9'h07B);
        133:     step(1'b1, 1'b1, 9'h0AA);
        default: step(1'b0, 1'b0, 9'h000);
      endcase
    end
    do_reset(1);

    // No loads: the pre-reset pending value must never surface.
    repeat (80) step(1'b0, 1'b0, 9'h000);

    // Random traffic, including loads that land on frame edges.
    repeat (400) step_rand(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
